lorenz_frame_packetizer: RTL and testbench
==========================================

Name: lorenz_frame_packetizer

Overview:
- Sits between the Lorenz integrator outputs (x, y, z, 32-bit signed fixed point) and the byte-wide UART transmitter (start/data/active/done handshake).
- On a sample strobe it snapshots all three state variables in the same cycle, so they are coherent.
- It then streams a fixed 16-byte framed packet (sync, sequence, payload, checksum) one byte at a time to the UART.
- Replaces ad-hoc per-byte indexing of a single variable with a decimated, self-synchronising telemetry stream.

Parameters:
- SYNC0, 8'hA5, first sync byte.
- SYNC1, 8'h5A, second sync byte.
- DECIM, 1, number of eligible strobes per transmitted frame (legal range ≥1, ≤65535).

Ports:
- clk  in  1  system clock; same clock as the UART.
- rst  in  1  asynchronous, active-high reset.
- sample_stb  in  1  one-cycle pulse: new x/y/z is valid this cycle.
- x_in  in  32  signed x state.
- y_in  in  32  signed y state.
- z_in  in  32  signed z state.
- tx_start  out  1  one-cycle request to UART; connects to Tx_s.
- tx_data  out  8  byte to send; connects to Tx_Data.
- tx_active  in  1  UART busy.
- tx_done  in  1  one-cycle pulse: UART finished the current byte.
- busy  out  1  high from frame start until the last byte's tx_done.
- seq  out  8  sequence number of the current/last frame.
- overrun_cnt  out  8  count of dropped strobes, saturating.

Behaviour:
- Reset (async, rst=1): tx_start=0, tx_data=0, busy=0, seq=0, overrun_cnt=0, decimation counter=0, FSM=IDLE, snapshot registers=0. Outputs take reset values immediately, without waiting for a clock edge.
- FSM states: IDLE, ISSUE, WAIT.
- Eligible strobe: sample_stb=1 while state=IDLE and tx_active=0.
- IDLE, eligible strobe, dec_cnt==DECIM-1:
  - dec_cnt<=0.
  - Snapshot x_in/y_in/z_in on this edge.
  - Byte index<=0, busy<=1, go to ISSUE.
- IDLE, eligible strobe, dec_cnt<DECIM-1: dec_cnt<=dec_cnt+1, stay in IDLE.
- Overrun: sample_stb=1 when not eligible (state≠IDLE or tx_active=1). overrun_cnt increments, saturating at 255. Decimation counter is unchanged and the snapshot is untouched.
- ISSUE: tx_start=1 for exactly this one cycle, tx_data=byte[index], go to WAIT.
- WAIT:
  - tx_data holds stable; tx_start=0.
  - On tx_done with index<15: index+1, go to ISSUE. The next tx_start occurs the cycle after tx_done.
  - On tx_done with index==15: busy<=0, seq<=seq+1 (wraps 255→0), go to IDLE.
- Latency: the strobe edge is captured in cycle n; tx_start=1 with tx_data=SYNC0 in cycle n+1.
- Frame byte order (index 0..15):
  - 0: SYNC0.
  - 1: SYNC1.
  - 2: seq.
  - 3–6: x, little-endian (x[7:0] first).
  - 7–10: y, little-endian.
  - 11–14: z, little-endian.
  - 15: checksum.
- Checksum: modulo-256 sum of bytes 2..14. Accumulate it incrementally as bytes issue, or precompute it at snapshot; both meet the spec. Sync bytes are excluded.
- seq output: holds the value embedded in the frame being sent; increments only after the frame completes.
- tx_done outside WAIT is ignored.
- tx_done coincident with sample_stb on the last byte: the strobe counts as an overrun, because state≠IDLE in that cycle.
- DECIM=1: every eligible strobe sends a frame; dec_cnt stays 0.
- Reset mid-frame: the frame is abandoned and everything returns to reset values. The next frame requires tx_active=0, so a byte already in flight in the UART finishes before a new SYNC0 is issued.
- Arithmetic: payload bytes are raw two's-complement bit slices; no sign handling is performed.

Test Plan:
- Basic frame: rst pulse; DECIM=1; x=32'h01020304, y=0, z=32'hFFFFFFFF; one strobe.
  - Required byte stream: A5 5A 00 04 03 02 01 00 00 00 00 FF FF FF FF 06.
  - Exactly 16 tx_start pulses; seq=1 after the final tx_done.
  - tx_start appears 1 cycle after the strobe, and 1 cycle after each tx_done.
- Overrun: DECIM=1; strobes every 10 cycles while the UART takes 100 cycles per byte.
  - Strobes during the frame are dropped and overrun_cnt counts them; 300 dropped strobes leave overrun_cnt=255.
  - Snapshot payload equals the first strobe's values.
- Decimation: DECIM=4; 8 eligible strobes spaced beyond the frame duration.
  - Exactly 2 frames, started by strobes 4 and 8; seq bytes 00 then 01.
- Sequence wrap: 257 frames → frame 256 carries seq 00, and its checksum includes the wrapped seq.
- Reset mid-frame: assert rst during byte 7 with tx_active=1.
  - All outputs take reset values immediately.
  - A strobe while tx_active=1 is not taken (overrun_cnt=1).
  - The next strobe after tx_active falls starts a full frame with seq=00.
- Spurious tx_done in IDLE → no tx_start, no state change.

Source files
------------

// File: rtl/lorenz_frame_packetizer.sv
// Snapshots the Lorenz x/y/z state on a sample strobe and streams it to a byte UART
// as a 16-byte frame: sync pair, sequence number, x/y/z little-endian, mod-256 checksum.
`timescale 1ns/1ps
module lorenz_frame_packetizer #(
    parameter logic [7:0]  SYNC0 = 8'hA5,
    parameter logic [7:0]  SYNC1 = 8'h5A,
    parameter int unsigned DECIM = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample_stb,
    input  logic signed [31:0] x_in,
    input  logic signed [31:0] y_in,
    input  logic signed [31:0] z_in,
    output logic               tx_start,
    output logic [7:0]         tx_data,
    input  logic               tx_active,
    input  logic               tx_done,
    output logic               busy,
    output logic [7:0]         seq,
    output logic [7:0]         overrun_cnt
);

    localparam logic [15:0] DEC_LAST = 16'(DECIM - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t             state, state_nxt;
    logic [15:0]        dec_cnt;
    logic [3:0]         idx;
    logic signed [31:0] x_snap, y_snap, z_snap;
    logic [7:0]         csum;
    logic               eligible, take, byte_done, frame_done;

    function automatic logic [7:0] frame_sum(input logic [7:0] s,
                                             input logic signed [31:0] x,
                                             input logic signed [31:0] y,
                                             input logic signed [31:0] z);
        frame_sum = s + x[7:0] + x[15:8] + x[23:16] + x[31:24]
                      + y[7:0] + y[15:8] + y[23:16] + y[31:24]
                      + z[7:0] + z[15:8] + z[23:16] + z[31:24];
    endfunction

    function automatic logic [7:0] frame_byte(input logic [3:0] i,
                                              input logic [7:0] s,
                                              input logic signed [31:0] x,
                                              input logic signed [31:0] y,
                                              input logic signed [31:0] z,
                                              input logic [7:0] c);
        case (i)
            4'd0:    frame_byte = SYNC0;
            4'd1:    frame_byte = SYNC1;
            4'd2:    frame_byte = s;
            4'd3:    frame_byte = x[7:0];
            4'd4:    frame_byte = x[15:8];
            4'd5:    frame_byte = x[23:16];
            4'd6:    frame_byte = x[31:24];
            4'd7:    frame_byte = y[7:0];
            4'd8:    frame_byte = y[15:8];
            4'd9:    frame_byte = y[23:16];
            4'd10:   frame_byte = y[31:24];
            4'd11:   frame_byte = z[7:0];
            4'd12:   frame_byte = z[15:8];
            4'd13:   frame_byte = z[23:16];
            4'd14:   frame_byte = z[31:24];
            default: frame_byte = c;
        endcase
    endfunction

    // A strobe is only usable when idle and the UART has drained any in-flight byte.
    assign eligible   = sample_stb && (state == S_IDLE) && !tx_active;
    assign take       = eligible && (dec_cnt == DEC_LAST);
    assign byte_done  = (state == S_WAIT) && tx_done && (idx != 4'd15);
    assign frame_done = (state == S_WAIT) && tx_done && (idx == 4'd15);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tx_start  = 1'b0;
        case (state)
            S_IDLE:  if (take) state_nxt = S_ISSUE;
            S_ISSUE: begin
                tx_start  = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT:  if (tx_done) state_nxt = (idx == 4'd15) ? S_IDLE : S_ISSUE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // tx_data is loaded on entry to ISSUE so it is valid with tx_start and holds through WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_cnt     <= '0;
            idx         <= '0;
            x_snap      <= '0;
            y_snap      <= '0;
            z_snap      <= '0;
            csum        <= '0;
            tx_data     <= '0;
            busy        <= 1'b0;
            seq         <= '0;
            overrun_cnt <= '0;
        end else begin
            if (take) begin
                dec_cnt <= '0;
                x_snap  <= x_in;
                y_snap  <= y_in;
                z_snap  <= z_in;
                csum    <= frame_sum(seq, x_in, y_in, z_in);
                idx     <= '0;
                busy    <= 1'b1;
                tx_data <= SYNC0;
            end else if (eligible) begin
                dec_cnt <= dec_cnt + 16'd1;
            end
            if (byte_done) begin
                idx     <= idx + 4'd1;
                tx_data <= frame_byte(idx + 4'd1, seq, x_snap, y_snap, z_snap, csum);
            end
            if (frame_done) begin
                busy <= 1'b0;
                seq  <= seq + 8'd1;
            end
            if (sample_stb && !((state == S_IDLE) && !tx_active) && (overrun_cnt != 8'hFF))
                overrun_cnt <= overrun_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_lorenz_frame_packetizer.sv
// Randomized bench for lorenz_frame_packetizer: two instances (DECIM=1 and DECIM=4),
// a UART stand-in, and a frame-level reference model built from the framing rules.
`timescale 1ns/1ps
module tb_lorenz_frame_packetizer;

    localparam int DEC0 = 1;
    localparam int DEC1 = 4;

    logic        clk;
    logic        rst;
    logic [31:0] xi, yi, zi;
    logic        stb       [2];
    logic        spur      [2];
    logic        act       [2];
    logic        done_r    [2];
    logic        tx_start_w[2];
    logic [7:0]  tx_data_w [2];
    logic        busy_w    [2];
    logic [7:0]  seq_w     [2];
    logic [7:0]  ovr_w     [2];

    int checks   = 0;
    int failures = 0;

    // reference model state, owned by the clocked model process
    bit         mbusy    [2];
    bit         exp_start[2];
    logic [7:0] mseq     [2];
    logic [7:0] movr     [2];
    int         mdec     [2];
    int         mcnt     [2];
    int         ucnt     [2];
    int         start_cnt[2];
    logic [7:0] ulast    [2];
    logic [7:0] exp_q    [2][$];
    logic [7:0] got_q    [2][$];
    int         byte_time[2];

    lorenz_frame_packetizer #(.SYNC0(8'hA5), .SYNC1(8'h5A), .DECIM(DEC0)) u0 (
        .clk(clk), .rst(rst), .sample_stb(stb[0]),
        .x_in(xi), .y_in(yi), .z_in(zi),
        .tx_start(tx_start_w[0]), .tx_data(tx_data_w[0]),
        .tx_active(act[0]), .tx_done(done_r[0] | spur[0]),
        .busy(busy_w[0]), .seq(seq_w[0]), .overrun_cnt(ovr_w[0])
    );

    lorenz_frame_packetizer #(.SYNC0(8'hA5), .SYNC1(8'h5A), .DECIM(DEC1)) u1 (
        .clk(clk), .rst(rst), .sample_stb(stb[1]),
        .x_in(xi), .y_in(yi), .z_in(zi),
        .tx_start(tx_start_w[1]), .tx_data(tx_data_w[1]),
        .tx_active(act[1]), .tx_done(done_r[1] | spur[1]),
        .busy(busy_w[1]), .seq(seq_w[1]), .overrun_cnt(ovr_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // UART stand-in (not reset, so an in-flight byte survives a packetizer reset) plus model
    always @(posedge clk) begin : model
        bit         was_busy, done_now, nxt;
        logic [7:0] fr [16];
        logic [7:0] sum;
        int         dec;
        for (int g = 0; g < 2; g++) begin
            done_now = done_r[g] | spur[g];
            dec      = (g == 0) ? DEC0 : DEC1;
            done_r[g] <= 1'b0;
            if (act[g]) begin
                if (ucnt[g] <= 1) begin
                    act[g]    <= 1'b0;
                    done_r[g] <= 1'b1;
                end else begin
                    ucnt[g] <= ucnt[g] - 1;
                end
            end else if (tx_start_w[g]) begin
                act[g]   <= 1'b1;
                ucnt[g]  <= byte_time[g];
                ulast[g]  = tx_data_w[g];
                got_q[g].push_back(tx_data_w[g]);
                start_cnt[g]++;
            end
            if (rst) begin
                mbusy[g]     = 1'b0;
                exp_start[g] = 1'b0;
                mseq[g]      = 8'd0;
                movr[g]      = 8'd0;
                mdec[g]      = 0;
                mcnt[g]      = 0;
                exp_q[g].delete();
            end else begin
                was_busy = mbusy[g];
                nxt      = 1'b0;
                if (tx_start_w[g] || exp_start[g])
                    check("tx_start", 32'(tx_start_w[g]), 32'(exp_start[g]));
                if (tx_start_w[g]) begin
                    if (exp_q[g].size() == 0)
                        check("byte_queue", 32'(exp_q[g].size()), 32'd1);
                    else
                        check("byte", 32'(tx_data_w[g]), 32'(exp_q[g].pop_front()));
                end
                if (done_r[g] && was_busy)
                    check("tx_hold", 32'(tx_data_w[g]), 32'(ulast[g]));
                if (stb[g]) begin
                    if (!was_busy && !act[g]) begin
                        if (mdec[g] == dec - 1) begin
                            mdec[g] = 0;
                            fr[0] = 8'hA5;
                            fr[1] = 8'h5A;
                            fr[2] = mseq[g];
                            for (int k = 0; k < 4; k++) begin
                                fr[3 + k]  = 8'((xi >> (8 * k)) & 32'hFF);
                                fr[7 + k]  = 8'((yi >> (8 * k)) & 32'hFF);
                                fr[11 + k] = 8'((zi >> (8 * k)) & 32'hFF);
                            end
                            sum = 8'd0;
                            for (int k = 2; k < 15; k++) sum = sum + fr[k];
                            fr[15] = sum;
                            for (int k = 0; k < 16; k++) exp_q[g].push_back(fr[k]);
                            mbusy[g] = 1'b1;
                            mcnt[g]  = 0;
                            nxt      = 1'b1;
                        end else begin
                            mdec[g]++;
                        end
                    end else if (movr[g] != 8'd255) begin
                        movr[g]++;
                    end
                end
                if (done_now && was_busy) begin
                    mcnt[g]++;
                    if (mcnt[g] == 16) begin
                        mbusy[g] = 1'b0;
                        mseq[g]  = mseq[g] + 8'd1;
                    end else begin
                        nxt = 1'b1;
                    end
                end
                exp_start[g] = nxt;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            for (int g = 0; g < 2; g++) begin
                check("busy", 32'(busy_w[g]), 32'(mbusy[g]));
                check("seq", 32'(seq_w[g]), 32'(mseq[g]));
                check("overrun", 32'(ovr_w[g]), 32'(movr[g]));
            end
        end
    end

    task automatic chk_rst(input int g);
        check("rst_tx_start", 32'(tx_start_w[g]), 32'd0);
        check("rst_tx_data", 32'(tx_data_w[g]), 32'd0);
        check("rst_busy", 32'(busy_w[g]), 32'd0);
        check("rst_seq", 32'(seq_w[g]), 32'd0);
        check("rst_overrun", 32'(ovr_w[g]), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic pulse(input int g, input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        @(negedge clk);
        xi = x; yi = y; zi = z;
        stb[g] = 1'b1;
        @(negedge clk);
        stb[g] = 1'b0;
    endtask

    task automatic wait_idle(input int g, input int limit);
        int n = 0;
        while ((mbusy[g] || act[g] || done_r[g]) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(mbusy[g] | act[g]), 32'd0);
        @(negedge clk);
    endtask

    logic [7:0] golden [16] = '{8'hA5, 8'h5A, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00,
                                8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h06};

    initial begin
        int          b, s, n;
        logic [31:0] x1, x4, x8, v;
        logic [7:0]  seq_before;
        rst = 1'b0;
        xi = '0; yi = '0; zi = '0;
        for (int g = 0; g < 2; g++) begin
            stb[g] = 1'b0; spur[g] = 1'b0; byte_time[g] = 3;
        end
        #2 rst = 1'b1;
        #1 chk_rst(0);
        chk_rst(1);
        @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;

        // basic frame against the literal byte stream
        b = got_q[0].size(); s = start_cnt[0];
        pulse(0, 32'h01020304, 32'h0, 32'hFFFFFFFF);
        wait_idle(0, 2000);
        check("basic_starts", 32'(start_cnt[0] - s), 32'd16);
        for (int i = 0; i < 16; i++)
            if (got_q[0].size() > b + i) check("basic_byte", 32'(got_q[0][b + i]), 32'(golden[i]));
        check("basic_seq", 32'(seq_w[0]), 32'd1);

        // random strobes on both instances, including strobes during frames
        byte_time[0] = int'($urandom_range(1, 4));
        byte_time[1] = int'($urandom_range(1, 4));
        repeat (600) begin
            @(negedge clk);
            xi = $urandom; yi = $urandom; zi = $urandom;
            stb[0] = ($urandom_range(0, 7) == 0);
            stb[1] = ($urandom_range(0, 5) == 0);
        end
        @(negedge clk);
        stb[0] = 1'b0; stb[1] = 1'b0;
        wait_idle(0, 3000);
        wait_idle(1, 3000);

        // overrun saturation with a slow UART
        do_reset();
        byte_time[0] = 100;
        b = got_q[0].size();
        x1 = $urandom;
        pulse(0, x1, $urandom, $urandom);
        repeat (8) @(negedge clk);
        repeat (299) begin
            pulse(0, $urandom, $urandom, $urandom);
            repeat (8) @(negedge clk);
        end
        check("ovr_saturate", 32'(ovr_w[0]), 32'd255);
        if (got_q[0].size() >= b + 7) begin
            v = {got_q[0][b + 6], got_q[0][b + 5], got_q[0][b + 4], got_q[0][b + 3]};
            check("ovr_payload", v, x1);
        end else begin
            check("ovr_bytes", 32'(got_q[0].size() - b), 32'd7);
        end
        wait_idle(0, 4000);

        // decimation by 4: strobes 4 and 8 start frames
        do_reset();
        byte_time[1] = 2;
        b = got_q[1].size(); s = start_cnt[1];
        x4 = '0; x8 = '0;
        for (int k = 1; k <= 8; k++) begin
            v = $urandom;
            if (k == 4) x4 = v;
            if (k == 8) x8 = v;
            pulse(1, v, $urandom, $urandom);
            wait_idle(1, 500);
            repeat (5) @(negedge clk);
        end
        check("dec_starts", 32'(start_cnt[1] - s), 32'd32);
        if (got_q[1].size() >= b + 32) begin
            check("dec_seq0", 32'(got_q[1][b + 2]), 32'd0);
            check("dec_seq1", 32'(got_q[1][b + 18]), 32'd1);
            check("dec_x4", {got_q[1][b + 6], got_q[1][b + 5], got_q[1][b + 4], got_q[1][b + 3]}, x4);
            check("dec_x8", {got_q[1][b + 22], got_q[1][b + 21], got_q[1][b + 20], got_q[1][b + 19]}, x8);
        end

        // sequence wrap over 257 frames
        do_reset();
        byte_time[0] = 1;
        b = got_q[0].size();
        for (int f = 0; f < 257; f++) begin
            pulse(0, $urandom, $urandom, $urandom);
            wait_idle(0, 300);
        end
        check("wrap_frames", 32'(got_q[0].size() - b), 32'd4112);
        if (got_q[0].size() >= b + 4112) begin
            check("wrap_seq255", 32'(got_q[0][b + 255 * 16 + 2]), 32'd255);
            check("wrap_seq0", 32'(got_q[0][b + 256 * 16 + 2]), 32'd0);
        end
        check("wrap_seq_out", 32'(seq_w[0]), 32'd1);

        // reset during byte 7 while the UART is busy
        byte_time[0] = 20;
        s = start_cnt[0];
        pulse(0, $urandom, $urandom, $urandom);
        n = 0;
        while (start_cnt[0] - s < 8 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("mid_byte7", 32'(start_cnt[0] - s), 32'd8);
        #2 rst = 1'b1;
        #1 chk_rst(0);
        @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        pulse(0, $urandom, $urandom, $urandom);
        check("mid_overrun", 32'(ovr_w[0]), 32'd1);
        check("mid_no_start", 32'(start_cnt[0] - s), 32'd8);
        n = 0;
        while ((act[0] || done_r[0]) && n < 100) begin
            @(negedge clk);
            n++;
        end
        b = got_q[0].size(); s = start_cnt[0];
        pulse(0, $urandom, $urandom, $urandom);
        wait_idle(0, 2000);
        check("mid_starts", 32'(start_cnt[0] - s), 32'd16);
        if (got_q[0].size() >= b + 3) begin
            check("mid_sync0", 32'(got_q[0][b]), 32'hA5);
            check("mid_seq", 32'(got_q[0][b + 2]), 32'd0);
        end

        // spurious tx_done while idle
        s = start_cnt[0];
        seq_before = seq_w[0];
        @(negedge clk);
        spur[0] = 1'b1;
        @(negedge clk);
        spur[0] = 1'b0;
        repeat (5) @(negedge clk);
        check("spur_start", 32'(start_cnt[0] - s), 32'd0);
        check("spur_busy", 32'(busy_w[0]), 32'd0);
        check("spur_seq", 32'(seq_w[0]), 32'(seq_before));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
